mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/rr_arb2.sv | 18 +
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory arbiter: memory op codes, FSM encoding
// and the op-validity helper.
package mem_ctrl_pkg;

    typedef logic [2:0]  op_t;
    typedef logic [3:0]  addr_t;
    typedef logic [15:0] data_t;

    localparam op_t OP_WAIT  = 3'd0;
    localparam op_t OP_GET   = 3'd1;
    localparam op_t OP_SET   = 3'd2;
    localparam op_t OP_CLEAR = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic op_valid(input op_t op);
        return (op == OP_GET) || (op == OP_SET) || (op == OP_CLEAR);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester A/B handshakes plus the shared memory port, bundled as one bus.
interface mem_arbiter_if;
    import mem_ctrl_pkg::*;

    logic  a_req;
    op_t   a_op;
    addr_t a_addr;
    data_t a_wdata;
    logic  a_ack;
    data_t a_rdata;

    logic  b_req;
    op_t   b_op;
    addr_t b_addr;
    data_t b_wdata;
    logic  b_ack;
    data_t b_rdata;

    logic  err;

    op_t   mem_operation;
    addr_t mem_address;
    data_t mem_data_in;
    data_t mem_data_out;
    logic  mem_done;

    // Arbiter side
    modport slave (
        input  a_req, a_op, a_addr, a_wdata,
        input  b_req, b_op, b_addr, b_wdata,
        input  mem_data_out, mem_done,
        output a_ack, a_rdata, b_ack, b_rdata, err,
        output mem_operation, mem_address, mem_data_in
    );

    // Requesters and memory side
    modport master (
        output a_req, a_op, a_addr, a_wdata,
        output b_req, b_op, b_addr, b_wdata,
        output mem_data_out, mem_done,
        input  a_ack, a_rdata, b_ack, b_rdata, err,
        input  mem_operation, mem_address, mem_data_in
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the side not granted last wins.
// req[0]/grant[0] is requester A, req[1]/grant[1] is requester B;
// last=1 means B was granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant, favouring the requester that did not win last time
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single memory port, one transaction at a
// time, with invalid-op rejection and a WAIT timeout.
//
//   state | meaning
//   IDLE  | no transaction; grant on any request
//   WAIT  | op driven to memory, waiting for mem_done or timeout
//   RESP  | ack/err pulse cycle, then back to IDLE
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] CNT_TC = 4'(TIMEOUT - 1);

    state_e     state_q, state_d;
    op_t        op_q, op_d;
    logic       gnt_b_q, gnt_b_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    op_t        mem_op_q, mem_op_d;
    addr_t      mem_addr_q, mem_addr_d;
    data_t      mem_wdata_q, mem_wdata_d;
    logic       a_ack_q, a_ack_d;
    logic       b_ack_q, b_ack_d;
    logic       err_q, err_d;
    data_t      a_rdata_q, a_rdata_d;
    data_t      b_rdata_q, b_rdata_d;

    logic [1:0] grant;
    op_t        sel_op;
    addr_t      sel_addr;
    data_t      sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req   ({bus.b_req, bus.a_req}),
        .last  (last_q),
        .grant (grant)
    );

    assign sel_op    = grant[1] ? bus.b_op    : bus.a_op;
    assign sel_addr  = grant[1] ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = grant[1] ? bus.b_wdata : bus.a_wdata;

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        gnt_b_d     = gnt_b_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_op_d    = mem_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        a_ack_d     = a_ack_q;
        b_ack_d     = b_ack_q;
        err_d       = err_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    gnt_b_d     = grant[1];
                    last_d      = grant[1];
                    cnt_d       = '0;
                    op_d        = sel_op;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    // An invalid op never reaches the memory
                    mem_op_d    = op_valid(sel_op) ? sel_op : OP_WAIT;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (!op_valid(op_q)) begin
                    a_ack_d = !gnt_b_q;
                    b_ack_d = gnt_b_q;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (bus.mem_done) begin
                    mem_op_d = OP_WAIT;
                    if (op_q == OP_GET) begin
                        if (gnt_b_q) b_rdata_d = bus.mem_data_out;
                        else         a_rdata_d = bus.mem_data_out;
                    end
                    a_ack_d = !gnt_b_q;
                    b_ack_d = gnt_b_q;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_TC) begin
                    mem_op_d = OP_WAIT;
                    a_ack_d  = !gnt_b_q;
                    b_ack_d  = gnt_b_q;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                a_ack_d = 1'b0;
                b_ack_d = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_WAIT;
            gnt_b_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            mem_op_q    <= OP_WAIT;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            gnt_b_q     <= gnt_b_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            err_q       <= err_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign bus.mem_operation = mem_op_q;
    assign bus.mem_address   = mem_addr_q;
    assign bus.mem_data_in   = mem_wdata_q;
    assign bus.a_ack         = a_ack_q;
    assign bus.b_ack         = b_ack_q;
    assign bus.err           = err_q;
    assign bus.a_rdata       = a_rdata_q;
    assign bus.b_rdata       = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, hand-written timeout,
// reset and contention sequences, and an ack-driven scoreboard.
module tb_mem_arbiter;

    localparam int TO = 15;

    typedef struct {
        bit          who;   // 0 = A, 1 = B
        logic [2:0]  op;
        logic [3:0]  addr;
        logic [15:0] wdata;
        int          lat;
        bit          err;
        logic [15:0] rd;
    } vec_t;

    typedef struct {
        bit          who;
        bit          err;
        logic [15:0] rd;
    } exp_t;

    logic clk;
    logic rst;
    bit   mem_stall;
    int   n_cmp;
    int   n_fail;

    exp_t        sb[$];
    vec_t        vecs[14];
    logic [15:0] mem_q[16];
    int          m_st;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Memory model: IDLE -> DECODER (performs op, raises done) -> GET/SET/CLEAR
    initial begin
        for (int i = 0; i < 16; i++) mem_q[i] = 16'hA000 + 16'(i);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st             <= 0;
            bus.mem_done     <= 1'b0;
            bus.mem_data_out <= 16'h0000;
        end else begin
            case (m_st)
                0: begin
                    bus.mem_done <= 1'b0;
                    if (bus.mem_operation != 3'd0 && !mem_stall) m_st <= 1;
                end
                1: begin
                    m_st         <= 2;
                    bus.mem_done <= 1'b1;
                    case (bus.mem_operation)
                        3'd1: bus.mem_data_out <= mem_q[bus.mem_address];
                        3'd2: begin
                            mem_q[bus.mem_address] <= bus.mem_data_in;
                            bus.mem_data_out       <= 16'hDEAD;
                        end
                        3'd3: begin
                            mem_q[bus.mem_address] <= 16'h0000;
                            bus.mem_data_out       <= 16'hDEAD;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    bus.mem_done <= 1'b0;
                    m_st         <= 0;
                end
            endcase
        end
    end

    // Scoreboard: every ack pops the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.a_ack && bus.b_ack) check("ack_exclusive", 32'(bus.b_ack), 32'(1'b0));
            if (bus.a_ack || bus.b_ack) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got a_ack=%0b b_ack=%0b expected none", bus.a_ack, bus.b_ack);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_port", 32'(bus.b_ack), 32'(e.who));
                    check("ack_err", 32'(bus.err), 32'(e.err));
                    check("ack_rdata", 32'(bus.b_ack ? bus.b_rdata : bus.a_rdata), 32'(e.rd));
                end
            end
        end
    end

    task automatic check_all_zero(input string nm);
        check({nm, "_mem_op"},  32'(bus.mem_operation), 32'd0);
        check({nm, "_mem_adr"}, 32'(bus.mem_address),   32'd0);
        check({nm, "_mem_din"}, 32'(bus.mem_data_in),   32'd0);
        check({nm, "_a_ack"},   32'(bus.a_ack),         32'd0);
        check({nm, "_b_ack"},   32'(bus.b_ack),         32'd0);
        check({nm, "_err"},     32'(bus.err),           32'd0);
        check({nm, "_a_rd"},    32'(bus.a_rdata),       32'd0);
        check({nm, "_b_rd"},    32'(bus.b_rdata),       32'd0);
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        exp_t e;
        bit   got;
        bit   valid;
        int   lat;
        valid = (v.op >= 3'd1) && (v.op <= 3'd3);
        e.who = v.who;
        e.err = v.err;
        e.rd  = v.rd;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!v.who) begin
            bus.a_req = 1'b1; bus.a_op = v.op; bus.a_addr = v.addr; bus.a_wdata = v.wdata;
        end else begin
            bus.b_req = 1'b1; bus.b_op = v.op; bus.b_addr = v.addr; bus.b_wdata = v.wdata;
        end
        got = 1'b0;
        lat = 0;
        while (!got && lat < TO + 8) begin
            @(posedge clk); #1;
            lat++;
            if (bus.a_ack || bus.b_ack) got = 1'b1;
            if (!valid) begin
                check({nm, "_memop_inv"}, 32'(bus.mem_operation), 32'd0);
            end else if (lat == 1) begin
                check({nm, "_memop"}, 32'(bus.mem_operation), 32'(v.op));
                check({nm, "_memadr"}, 32'(bus.mem_address), 32'(v.addr));
                check({nm, "_memdin"}, 32'(bus.mem_data_in), 32'(v.wdata));
            end
        end
        check({nm, "_latency"}, 32'(lat), 32'(v.lat));
        if (got) check({nm, "_memop_at_ack"}, 32'(bus.mem_operation), 32'd0);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(posedge clk); #1;
        check({nm, "_ack_1cyc"}, 32'(bus.a_ack | bus.b_ack | bus.err), 32'd0);
    endtask

    task automatic wait_ack(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < TO + 8 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.a_ack || bus.b_ack) got = 1'b1;
        end
        check({nm, "_ack_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t  t;
        exp_t  e;
        n_cmp = 0;
        n_fail = 0;
        mem_stall = 1'b0;
        rst = 1'b1;
        bus.a_req = 1'b0; bus.a_op = 3'd0; bus.a_addr = 4'd0; bus.a_wdata = 16'd0;
        bus.b_req = 1'b0; bus.b_op = 3'd0; bus.b_addr = 4'd0; bus.b_wdata = 16'd0;

        //           who   op    addr   wdata     lat err  rdata
        vecs[0]  = '{1'b0, 3'd2, 4'h5, 16'hBEEF, 4, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 3'd1, 4'h5, 16'h0000, 4, 1'b0, 16'hBEEF};
        vecs[2]  = '{1'b0, 3'd2, 4'h3, 16'h1234, 4, 1'b0, 16'hBEEF};
        vecs[3]  = '{1'b1, 3'd3, 4'h3, 16'h0000, 4, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 3'd1, 4'h3, 16'h0000, 4, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 3'd1, 4'h5, 16'h0000, 4, 1'b0, 16'hBEEF};
        vecs[6]  = '{1'b0, 3'd5, 4'h7, 16'h7777, 2, 1'b1, 16'h0000};
        vecs[7]  = '{1'b1, 3'd0, 4'h8, 16'h8888, 2, 1'b1, 16'hBEEF};
        vecs[8]  = '{1'b1, 3'd2, 4'hF, 16'h55AA, 4, 1'b0, 16'hBEEF};
        vecs[9]  = '{1'b1, 3'd1, 4'hF, 16'h0000, 4, 1'b0, 16'h55AA};
        vecs[10] = '{1'b0, 3'd7, 4'h1, 16'h0001, 2, 1'b1, 16'h0000};
        vecs[11] = '{1'b0, 3'd1, 4'hF, 16'h0000, 4, 1'b0, 16'h55AA};
        vecs[12] = '{1'b0, 3'd1, 4'h0, 16'h0000, 4, 1'b0, 16'hA000};
        vecs[13] = '{1'b1, 3'd1, 4'h1, 16'h0000, 4, 1'b0, 16'hA001};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Timeout: B write with a stalled memory; the write must not land
        mem_stall = 1'b1;
        t = '{1'b1, 3'd2, 4'h2, 16'h1111, TO + 1, 1'b1, 16'hA001};
        run_txn(t, "timeout");
        mem_stall = 1'b0;
        t = '{1'b0, 3'd1, 4'h2, 16'h0000, 4, 1'b0, 16'hA002};
        run_txn(t, "after_tmo");

        // Reset while in WAIT: no ack, everything cleared immediately
        @(posedge clk); #1;
        bus.a_req = 1'b1; bus.a_op = 3'd1; bus.a_addr = 4'h5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_pre_op", 32'(bus.mem_operation), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        bus.a_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_mid_idle_op", 32'(bus.mem_operation), 32'd0);

        // Contention after reset: A first, then B beats A's fresh request, then A
        e = '{1'b0, 1'b0, 16'hBEEF}; sb.push_back(e);
        e = '{1'b1, 1'b0, 16'h55AA}; sb.push_back(e);
        @(posedge clk); #1;
        bus.a_req = 1'b1; bus.a_op = 3'd1; bus.a_addr = 4'h5;
        bus.b_req = 1'b1; bus.b_op = 3'd1; bus.b_addr = 4'hF;
        wait_ack("cont_a1");
        check("cont_a1_port", 32'(bus.a_ack), 32'd1);
        bus.a_req = 1'b0;
        @(posedge clk); #1;
        e = '{1'b0, 1'b0, 16'hA000}; sb.push_back(e);
        bus.a_req = 1'b1; bus.a_addr = 4'h0;
        wait_ack("cont_b");
        check("cont_b_port", 32'(bus.b_ack), 32'd1);
        bus.b_req = 1'b0;
        wait_ack("cont_a2");
        check("cont_a2_port", 32'(bus.a_ack), 32'd1);
        bus.a_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
